// File: rtl/boid_frame_writer.sv
// boid_frame_writer: per-frame sequencer that swaps the display bank and then draws each boid
// as a clipped BOID_SIZE x BOID_SIZE square into the 1bpp display RAM.
module boid_frame_writer #(
  parameter int MAX_BOIDS           = 4,
  parameter int BITS_FOR_BOIDS      = $clog2(MAX_BOIDS),
  parameter int BOID_SIZE           = 2,
  parameter int VIDEO_WIDTH         = 640,
  parameter int VIDEO_HEIGHT        = 480,
  parameter int PIXEL_ADDRESS_WIDTH = 19
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           screen_end,
  input  logic [9:0]                     x_loc,
  input  logic [8:0]                     y_loc,
  output logic [BITS_FOR_BOIDS-1:0]      boid_sel,
  output logic                           fb_we,
  output logic [PIXEL_ADDRESS_WIDTH-1:0] fb_addr,
  output logic                           fb_data,
  output logic                           fb_swap,
  output logic                           busy,
  output logic                           overrun,
  output logic [15:0]                    frame_count
);
  typedef enum logic [1:0] {IDLE, SWAP, LOAD, DRAW} state_t;
  state_t state_q, state_d;
  logic [BITS_FOR_BOIDS-1:0] boid_sel_q, boid_sel_d;
  logic [9:0] bx_q, bx_d;
  logic [8:0] by_q, by_d;
  logic [2:0] dx_q, dx_d, dy_q, dy_d;
  logic overrun_q, overrun_d;
  logic [15:0] frame_count_q, frame_count_d;
  logic [10:0] px;
  logic [9:0] py;
  logic row_end, last_px, last_boid;
  always_comb begin
    px = 11'(bx_q) + 11'(dx_q);
    py = 10'(by_q) + 10'(dy_q);
    row_end = dx_q == 3'(BOID_SIZE - 1);
    last_px = row_end && dy_q == 3'(BOID_SIZE - 1);
    last_boid = boid_sel_q == BITS_FOR_BOIDS'(MAX_BOIDS - 1);
    state_d = state_q;
    boid_sel_d = boid_sel_q;
    bx_d = bx_q;
    by_d = by_q;
    dx_d = dx_q;
    dy_d = dy_q;
    // a pulse that arrives while drawing (including the final DRAW cycle) is dropped
    overrun_d = overrun_q | (screen_end && state_q != IDLE);
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE: begin
        state_d = screen_end ? SWAP : IDLE;
        boid_sel_d = screen_end ? '0 : boid_sel_q;
      end
      SWAP: state_d = LOAD;
      LOAD: begin
        bx_d = x_loc;
        by_d = y_loc;
        dx_d = '0;
        dy_d = '0;
        state_d = DRAW;
      end
      DRAW: begin
        dx_d = row_end ? 3'd0 : dx_q + 3'd1;
        dy_d = row_end ? dy_q + 3'd1 : dy_q;
        state_d = !last_px ? DRAW : last_boid ? IDLE : LOAD;
        boid_sel_d = (last_px && !last_boid) ? boid_sel_q + 1'b1 : boid_sel_q;
        frame_count_d = frame_count_q + 16'(last_px && last_boid);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      boid_sel_q <= '0;
      bx_q <= '0;
      by_q <= '0;
      dx_q <= '0;
      dy_q <= '0;
      overrun_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q <= state_d;
      boid_sel_q <= boid_sel_d;
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
      overrun_q <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end
  // y*640 as (y<<9)+(y<<7), then x added
  assign fb_addr = state_q == DRAW
    ? PIXEL_ADDRESS_WIDTH'((21'(py) << 9) + (21'(py) << 7) + 21'(px)) : '0;
  assign fb_we = state_q == DRAW && px < 11'(VIDEO_WIDTH) && py < 10'(VIDEO_HEIGHT);
  assign fb_data = 1'b1;
  assign fb_swap = state_q == SWAP;
  assign busy = state_q != IDLE;
  assign boid_sel = boid_sel_q;
  assign overrun = overrun_q;
  assign frame_count = frame_count_q;
endmodule

// File: tb/tb_boid_frame_writer.sv
// tb_boid_frame_writer: randomized scoreboard bench; expected pixel writes are queued per frame
// and a negedge monitor pops them whenever the DUT asserts fb_we.
module tb_boid_frame_writer;
  localparam int W = 640;
  localparam int H = 480;
  localparam int NB = 4;
  localparam int S = 2;
  localparam int BUSY_LEN = 1 + NB * (1 + S * S);
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic screen_end = 1'b0;
  logic [9:0] x_loc;
  logic [8:0] y_loc;
  logic [1:0] boid_sel;
  logic fb_we, fb_data, fb_swap, busy, overrun;
  logic [18:0] fb_addr;
  logic [15:0] frame_count;
  logic [9:0] xs [NB];
  logic [8:0] ys [NB];
  int unsigned exp_q[$];
  int total = 0;
  int bad = 0;
  logic [15:0] fc_exp = '0;
  logic ovr_exp = 1'b0;
  boid_frame_writer #(.MAX_BOIDS(NB), .BOID_SIZE(S)) dut (
    .clock(clock), .reset(reset), .screen_end(screen_end), .x_loc(x_loc), .y_loc(y_loc),
    .boid_sel(boid_sel), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
    .fb_swap(fb_swap), .busy(busy), .overrun(overrun), .frame_count(frame_count)
  );
  always #5 clock = ~clock;
  assign x_loc = xs[boid_sel];
  assign y_loc = ys[boid_sel];
  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask
  function automatic void push_boid(input int b);
    for (int dy = 0; dy < S; dy++)
      for (int dx = 0; dx < S; dx++) begin
        int px = int'(xs[b]) + dx;
        int py = int'(ys[b]) + dy;
        if (px < W && py < H) exp_q.push_back(py * W + px);
      end
  endfunction
  always @(negedge clock) begin
    if (!reset && fb_we) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected write: addr %0d with no write expected", fb_addr);
      end else begin
        chk("write addr", fb_addr, exp_q.pop_front());
        chk("fb_data", fb_data, 1);
      end
    end
  end
  // k_se: busy cycle in which a second screen_end is driven; k_rst: busy cycle in which reset is driven
  task automatic frame(input int k_se, input int k_rst, input int n_draw);
    int n;
    @(negedge clock);
    screen_end = 1'b1;
    for (int b = 0; b < n_draw; b++) push_boid(b);
    @(negedge clock);
    screen_end = 1'b0;
    chk("fb_swap", fb_swap, 1);
    chk("swap boid_sel", boid_sel, 0);
    n = 0;
    while (busy && n < 200) begin
      screen_end = (n + 1 == k_se);
      reset = (n + 1 == k_rst);
      n++;
      @(negedge clock);
    end
    screen_end = 1'b0;
    if (k_se > 0) ovr_exp = 1'b1;
    if (k_rst > 0) begin
      chk("busy before reset", n, k_rst);
      chk("fb_we after reset", fb_we, 0);
      reset = 1'b0;
      ovr_exp = 1'b0;
      fc_exp = '0;
      repeat (30) @(negedge clock);
    end else begin
      chk("busy cycles", n, BUSY_LEN);
      fc_exp = fc_exp + 16'd1;
      repeat (3) @(negedge clock);
    end
    chk("no restart", busy, 0);
    chk("pending writes", exp_q.size(), 0);
    chk("frame_count", frame_count, fc_exp);
    chk("overrun", overrun, ovr_exp);
    exp_q.delete();
  endtask
  task automatic set_boid(input int b, input int x, input int y);
    xs[b] = 10'(x);
    ys[b] = 9'(y);
  endtask
  initial begin
    for (int b = 0; b < NB; b++) set_boid(b, 0, 0);
    repeat (3) @(negedge clock);
    chk("reset fb_we", fb_we, 0);
    chk("reset fb_addr", fb_addr, 0);
    chk("reset fb_swap", fb_swap, 0);
    chk("reset busy", busy, 0);
    chk("reset overrun", overrun, 0);
    chk("reset frame_count", frame_count, 0);
    chk("reset boid_sel", boid_sel, 0);
    chk("fb_data", fb_data, 1);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    set_boid(0, 0, 0); set_boid(1, 100, 50); set_boid(2, 639, 0); set_boid(3, 0, 479);
    frame(0, 0, NB);
    for (int b = 0; b < NB; b++) set_boid(b, 10, 10);
    frame(0, 0, NB);
    set_boid(0, 639, 479); set_boid(1, 700, 20); set_boid(2, 5, 500); set_boid(3, 638, 478);
    frame(0, 0, NB);
    for (int i = 0; i < 15; i++) begin
      for (int b = 0; b < NB; b++)
        set_boid(b, $urandom_range(0, 3) == 0 ? $urandom_range(600, 1023) : $urandom_range(0, 639),
                    $urandom_range(0, 3) == 0 ? $urandom_range(450, 511) : $urandom_range(0, 479));
      frame(0, 0, NB);
    end
    set_boid(0, 20, 30); set_boid(1, 40, 60); set_boid(2, 300, 200); set_boid(3, 1, 2);
    frame(5, 0, NB);
    frame(BUSY_LEN, 0, NB);
    frame(0, 0, NB);
    set_boid(2, 1000, 500);
    frame(0, 1 + 2 * (1 + S * S) + 2, 2);
    set_boid(2, 320, 240);
    frame(0, 0, NB);
    @(negedge clock);
    force dut.frame_count_q = 16'hffff;
    #1 release dut.frame_count_q;
    fc_exp = 16'hffff;
    frame(0, 0, NB);
    chk("frame_count wrap", frame_count, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/boid_frame_writer.md
Name: boid_frame_writer

Overview:
Sequencer between the per-boid BPU position registers and the 1-bit-per-pixel boid display RAM that the VGA controller reads. On each screen_end pulse it swaps or clears the display buffer. It then walks every boid index, latches that boid's x/y, and writes a BOID_SIZE x BOID_SIZE square of set pixels into the RAM. It replaces the ad-hoc boid_counter/writing_to_boids_disp loop with a defined, clipped, overrun-checked FSM.

Parameters:
MAX_BOIDS, 4, number of BPU instances walked per frame
BITS_FOR_BOIDS, $clog2(MAX_BOIDS), width of boid_sel
BOID_SIZE, 2, side length in pixels of each drawn boid square (1..8)
VIDEO_WIDTH, 640, visible columns
VIDEO_HEIGHT, 480, visible rows
PIXEL_ADDRESS_WIDTH, 19, width of fb_addr

Ports:
clock  in  1  system clock (50 MHz domain shared with processor/BPUs)
reset  in  1  synchronous, active-high reset
screen_end  in  1  single-cycle pulse from the VGA controller at end of visible frame
x_loc  in  10  x of the boid selected by boid_sel (combinational BPU mux, valid same cycle)
y_loc  in  9  y of the boid selected by boid_sel
boid_sel  out  BITS_FOR_BOIDS  index of the boid being read
fb_we  out  1  display RAM write enable
fb_addr  out  PIXEL_ADDRESS_WIDTH  display RAM write address
fb_data  out  1  write data; constant 1
fb_swap  out  1  one-cycle pulse: switch to the cleared RAM bank
busy  out  1  high from SWAP through the last DRAW cycle
overrun  out  1  sticky; set when screen_end arrives while busy
frame_count  out  16  completed frames, wraps 65535 -> 0

Behaviour:
- Reset (sampled on clock edge): state=IDLE. boid_sel, fb_we, fb_addr, fb_swap, busy, overrun and frame_count all 0. fb_data is always 1.
- States: IDLE, SWAP, LOAD, DRAW.
- IDLE: if screen_end=1, go to SWAP. Otherwise hold.
- SWAP (1 cycle): fb_swap=1, busy=1, boid_sel=0. Go to LOAD.
- LOAD (1 cycle): register bx=x_loc and by=y_loc for the current boid_sel. Clear dx and dy to 0. Go to DRAW. fb_we=0.
- DRAW (BOID_SIZE^2 cycles):
  - Pixel position px=bx+dx, py=by+dy, computed at 11/10 bits with no truncation.
  - fb_addr = py*VIDEO_WIDTH + px, built by shift-add (py<<9)+(py<<7)+px, truncated to PIXEL_ADDRESS_WIDTH.
  - fb_we = (px<VIDEO_WIDTH) && (py<VIDEO_HEIGHT). Clipped pixels still use their cycle, with fb_we=0.
  - dx increments each cycle. When dx=BOID_SIZE-1, dx wraps to 0 and dy increments.
  - After dx=dy=BOID_SIZE-1:
    - If boid_sel==MAX_BOIDS-1: go to IDLE, frame_count+1, busy falls on the next cycle.
    - Otherwise boid_sel+1 and go to LOAD.
- Timing: fb_we and fb_addr are valid during the DRAW cycle itself and are sampled by the RAM on the next edge.
- Latency: screen_end sampled at edge t. fb_swap is high in cycle t+1. The first write is in cycle t+3. busy stays high for exactly 1+MAX_BOIDS*(1+BOID_SIZE^2) cycles.
- screen_end while busy: ignored (no restart), overrun<=1. overrun clears only on reset.
- screen_end in the same cycle as the final DRAW: treated as busy, so it is ignored and sets overrun.
- Reset mid-frame: abort immediately to IDLE, counters cleared, no further writes. The bank stays as last swapped.
- x_loc/y_loc changing during DRAW has no effect, because the values are latched in LOAD.

Test Plan:
- MAX_BOIDS=1, BOID_SIZE=2, boid at (10,10), pulse screen_end -> fb_swap one cycle later; fb_we on 4 consecutive cycles with fb_addr 6410, 6411, 7050, 7051; frame_count=1; busy high 6 cycles.
- Boid at (639,479), BOID_SIZE=2 -> only address 307199 is written (one fb_we); the other 3 DRAW cycles have fb_we=0; cycle count unchanged.
- MAX_BOIDS=4, BOID_SIZE=2, boids at (0,0), (100,50), (639,0), (0,479) -> boid_sel steps 0..3; writes {0,1,640,641}, {32100,32101,32740,32741}, {639,1279}, {306560,306561}; busy 21 cycles.
- Second screen_end 5 cycles after the first (mid-DRAW) -> no restart, overrun=1 and stays 1; frame_count ends at 1; a later idle screen_end starts a normal frame.
- Assert reset during DRAW of boid 2 -> next cycle state IDLE, fb_we=0, busy=0, frame_count=0, overrun=0; no further writes until the next screen_end.
- Force frame_count to 65535 and run one frame -> frame_count=0.
